// File: rtl/checker_fetch.sv
// checker_fetch: copies a block of host memory into the checker's 8-bank local RAM.
// Word reads go out on a valid/ready request channel. In-order completions are
// written one byte lane per bank, one cycle after they arrive.
module checker_fetch #(
    parameter int MEM_AW  = 3,
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic              abort,
    input  logic [63:0]       base_adr,
    input  logic [MEM_AW:0]   len,
    output logic              rq_valid,
    input  logic              rq_ready,
    output logic [63:0]       rq_adr,
    input  logic              cp_valid,
    input  logic              cp_err,
    input  logic [63:0]       cp_dat,
    output logic              mem_we,
    output logic [7:0]        mem_sel,
    output logic [MEM_AW-1:0] mem_adr,
    output logic [63:0]       mem_dat,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, REQ, DRAIN, DONE, ERR} state_t;

    // A full local RAM is the largest block that can be copied
    localparam logic [MEM_AW:0] MAX_LEN = {1'b1, {MEM_AW{1'b0}}};
    // The timeout fires on the edge where the counter would reach TIMEOUT
    localparam logic [7:0]      TO_LAST = 8'(TIMEOUT - 1);

    state_t          state, state_nx;
    logic [63:0]     base;
    logic [MEM_AW:0] lenr;
    logic [MEM_AW:0] issued;
    logic [MEM_AW:0] received;
    logic [MEM_AW:0] outstanding;
    logic [7:0]      tocnt;
    logic            in_xfer;
    logic            start_ok;
    logic            rq_fire;
    logic            cp_ok;
    logic            done_set;
    logic            timeout_hit;

    assign outstanding = issued - received;
    assign in_xfer     = (state == REQ) || (state == DRAIN);
    assign busy        = in_xfer;
    assign err         = (state == ERR);
    assign rq_adr      = base + (64'(issued) << 3);

    // State register; reset abandons any transfer in flight
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, request valid and the qualified events driving the datapath
    always_comb begin
        state_nx    = state;
        start_ok    = 1'b0;
        cp_ok       = 1'b0;
        done_set    = 1'b0;
        rq_valid    = (state == REQ) && (issued < lenr) && (int'(outstanding) < MAX_OUT);
        rq_fire     = rq_valid && rq_ready;
        timeout_hit = in_xfer && !cp_valid && (outstanding != '0) && (tocnt == TO_LAST);
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    start_ok = 1'b1;
                    if (len == '0) begin
                        state_nx = DONE;
                        done_set = 1'b1;
                    end else begin
                        state_nx = REQ;
                    end
                end
            end
            REQ, DRAIN: begin
                if (abort) begin
                    state_nx = ERR;
                end else if (cp_valid && (cp_err || (outstanding == '0))) begin
                    state_nx = ERR;
                end else if (timeout_hit) begin
                    state_nx = ERR;
                end else begin
                    cp_ok = cp_valid;
                    if ((state == REQ) && (issued == lenr)) begin
                        state_nx = DRAIN;
                    end else if ((state == DRAIN) && (received == lenr)) begin
                        state_nx = DONE;
                        done_set = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Transfer bookkeeping, timeout counter and the registered RAM write port
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            base     <= '0;
            lenr     <= '0;
            issued   <= '0;
            received <= '0;
            tocnt    <= '0;
            mem_we   <= 1'b0;
            mem_sel  <= '0;
            mem_adr  <= '0;
            mem_dat  <= '0;
            done     <= 1'b0;
        end else begin
            mem_we  <= 1'b0;
            mem_sel <= '0;
            done    <= done_set;
            if (start_ok) begin
                base     <= base_adr & ~64'h7;
                lenr     <= (len > MAX_LEN) ? MAX_LEN : len;
                issued   <= '0;
                received <= '0;
                tocnt    <= '0;
            end else begin
                if (rq_fire) begin
                    issued <= issued + 1'b1;
                end
                if (cp_ok) begin
                    received <= received + 1'b1;
                    mem_we   <= 1'b1;
                    mem_sel  <= 8'hFF;
                    mem_adr  <= received[MEM_AW-1:0];
                    mem_dat  <= cp_dat;
                    tocnt    <= '0;
                end else if (in_xfer && (outstanding != '0)) begin
                    tocnt <= tocnt + 1'b1;
                end
            end
        end
    end

endmodule
